fetch_unit: RTL and testbench

- Instruction-fetch front end of the RV32I pipeline; the producer side of the IF/ID interface that the decode/control stage consumes.
- Generates the PC and issues word requests to instruction memory. Buffers in-order responses in a 2-entry queue and presents {instr, pc} to decode with a valid/ready handshake.
- Handles redirects (branch/jump) and decode kills by discarding stale in-flight responses.

---
 rtl/fetch_unit_pkg.sv | 27 ++
 rtl/fetch_queue.sv | 71 +++++++
 rtl/fetch_unit.sv | 129 ++++++++++++
 tb/tb_fetch_unit.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   - RV32I opcode used to build the canonical NOP (addi x0, x0, 0)
//   - default reset PC and IF/ID queue depth
//   - fetch FSM state encoding and the IF/ID queue entry layout
package fetch_unit_pkg;

    localparam logic [6:0]  OPC_OP_IMM = 7'b001_0011;
    localparam logic [31:0] NOP_INSTR  = {12'h000, 5'd0, 3'b000, 5'd0, OPC_OP_IMM};

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int unsigned DEFAULT_QDEPTH   = 2;

    typedef enum logic {
        StBoot,
        StRun
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ifid_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched words for the IF/ID boundary.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   flush        empty the queue (wins over push and pop)
//   push         write push_data at the tail
//   push_data    entry to write
//   pop          drop the head (ignored when empty)
//   count        number of valid entries
//   empty        no valid entries
//   head         oldest entry, read combinationally from storage
module fetch_queue #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic [WIDTH-1:0]           head
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_q, wr_q;
    logic [CW-1:0]    cnt_q;
    logic             full;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_incr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign count   = cnt_q;
    assign head    = mem_q[rd_q];
    assign do_push = push && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= ptr_incr(wr_q);
            if (do_pop)  rd_q <= ptr_incr(rd_q);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: empty/count gate every read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_data;
    end

    // The producer's credit scheme guarantees a free slot for every push.
    push_not_full_a: assert property (@(posedge clk) disable iff (!rst_n)
        (push && !flush) |-> !full);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: generates the PC, issues word requests to
// instruction memory, queues in-order responses and presents {instr, pc}
// to decode. Redirects flush the queue and discard stale responses.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   imem_req_valid/ready/addr       fetch request channel (word aligned)
//   imem_rsp_valid/data             in-order response channel, no backpressure
//   redirect_valid/redirect_pc      taken branch/jump from execute
//   dec_kill                        decode discards the current head
//   ifid_valid/ready/instr/pc       IF/ID handshake towards decode
//   misalign_err                    pulse after a redirect with pc[1:0] != 0
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned QDEPTH   = DEFAULT_QDEPTH,
    parameter int unsigned CNTW     = 2  // 2**CNTW must exceed QDEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        dec_kill,
    output logic        ifid_valid,
    input  logic        ifid_ready,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic        misalign_err
);

    localparam int unsigned QCW = $clog2(QDEPTH + 1);
    localparam int unsigned OW  = CNTW + 1;

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  rsp_pc_q, rsp_pc_d;    // address of next non-stale response
    logic [CNTW-1:0] out_q, out_d;       // requests accepted, not yet answered
    logic [CNTW-1:0] drop_q, drop_d;     // stale responses still to discard
    logic         mis_q, mis_d;

    logic [QCW-1:0] q_count;
    logic           q_empty;
    ifid_entry_t    q_head;
    logic           q_push, q_pop;
    logic           req_fire;
    logic [OW-1:0]  occupancy;

    fetch_queue #(
        .DEPTH (QDEPTH),
        .WIDTH ($bits(ifid_entry_t))
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (q_push),
        .push_data ({imem_rsp_data, rsp_pc_q}),
        .pop       (q_pop),
        .count     (q_count),
        .empty     (q_empty),
        .head      (q_head)
    );

    assign ifid_valid = !q_empty;
    assign ifid_instr = q_empty ? NOP_INSTR : q_head.instr;
    assign ifid_pc    = q_empty ? 32'h0     : q_head.pc;
    assign q_pop      = ifid_valid && (ifid_ready || dec_kill);
    assign q_push     = imem_rsp_valid && !redirect_valid && (drop_q == '0);

    // Words already claimed (in flight or queued). A head leaving this cycle
    // frees its slot now, which is what sustains one word per cycle.
    assign occupancy = {1'b0, out_q} + OW'(q_count) - OW'(q_pop);

    assign imem_req_valid = (state_q == StRun) && !redirect_valid &&
                            (occupancy < OW'(QDEPTH));
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign misalign_err   = mis_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        out_d    = out_q + CNTW'(req_fire) - CNTW'(imem_rsp_valid);
        drop_d   = drop_q;
        mis_d    = 1'b0;

        case (state_q)
            StBoot:  state_d = StRun;
            StRun:   state_d = StRun;
            default: state_d = StBoot;
        endcase

        if (req_fire) pc_d = pc_q + 32'd4;
        if (q_push) rsp_pc_d = rsp_pc_q + 32'd4;
        if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CNTW'(1);

        if (redirect_valid) begin
            pc_d     = word_align(redirect_pc);
            rsp_pc_d = word_align(redirect_pc);
            // Everything still in flight after this cycle is stale.
            drop_d   = out_d;
            mis_d    = (redirect_pc[1:0] != 2'b00);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StBoot;
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            out_q    <= '0;
            drop_q   <= '0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
            mis_q    <= mis_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a memory model plus an epoch-tagged
// reference of the instruction stream, with directed pins and random traffic.
module tb_fetch_unit;

    localparam int QDEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_kill;
    logic        ifid_valid, ifid_ready;
    logic [31:0] ifid_instr, ifid_pc;
    logic        misalign_err;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (QDEPTH),
        .CNTW     (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_kill       (dec_kill),
        .ifid_valid     (ifid_valid),
        .ifid_ready     (ifid_ready),
        .ifid_instr     (ifid_instr),
        .ifid_pc        (ifid_pc),
        .misalign_err   (misalign_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dut_addr;
        logic [31:0] mdl_addr;
        int          epoch;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    mreq_t mem[$];   // accepted requests awaiting a response
    ent_t  mq[$];    // words decode should see, oldest first

    logic [31:0] mpc;
    int          epoch, cyc;
    bit          run;
    logic        mis_exp;

    int          p_mready, p_ready, p_kill, p_redir, lat;
    bit          lat_rand, rst_req, redir_next;
    logic [31:0] redir_target;

    logic        s_req_valid, s_ifid_valid, s_mis;
    logic [31:0] s_req_addr, s_ifid_pc, s_ifid_instr;

    int vectors, miscompares;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0003;
    endfunction

    function automatic bit roll(input int p);
        return int'($urandom_range(0, 99)) < p;
    endfunction

    function automatic logic [31:0] rand_target();
        logic [31:0] r;
        r = $urandom;
        if (roll(20)) return 32'hFFFF_FFF0 | (r & 32'h0000_000F);
        return r & 32'h0000_3FFF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mem.delete();
        mpc     = 32'h0;
        run     = 1'b0;
        mis_exp = 1'b0;
        epoch++;
    endtask

    // One clock: drive at negedge, compare 1ns later, update model at posedge.
    task automatic cycle();
        bit    pop_now, fire, exp_rv;
        int    occ, l;
        mreq_t h;

        @(negedge clk);
        rst_n = rst_req;
        if (!rst_n) mem.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (rst_n && mem.size() > 0 && mem[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word_of(mem[0].dut_addr);
        end
        imem_req_ready = roll(p_mready);
        ifid_ready     = roll(p_ready);
        dec_kill       = rst_n && roll(p_kill);
        redirect_valid = 1'b0;
        redirect_pc    = $urandom;
        if (rst_n && redir_next) begin
            redirect_valid = 1'b1;
            redirect_pc    = redir_target;
        end else if (rst_n && roll(p_redir)) begin
            redirect_valid = 1'b1;
            redirect_pc    = rand_target();
        end

        #1;
        s_req_valid  = imem_req_valid;
        s_req_addr   = imem_req_addr;
        s_ifid_valid = ifid_valid;
        s_ifid_pc    = ifid_pc;
        s_ifid_instr = ifid_instr;
        s_mis        = misalign_err;

        pop_now = (mq.size() > 0) && (ifid_ready || dec_kill);
        if (!rst_n) begin
            check("rst_req_valid", 32'(s_req_valid), 32'd0);
            check("rst_ifid_valid", 32'(s_ifid_valid), 32'd0);
            check("rst_ifid_instr", s_ifid_instr, 32'h0000_0013);
            check("rst_ifid_pc", s_ifid_pc, 32'h0);
            check("rst_misalign", 32'(s_mis), 32'd0);
        end else begin
            // Credit: claimed words (in flight + queued, minus a leaving head).
            occ    = mem.size() + mq.size() - (pop_now ? 1 : 0);
            exp_rv = run && !redirect_valid && (occ < QDEPTH);
            check("req_valid", 32'(s_req_valid), 32'(exp_rv));
            if (exp_rv && s_req_valid) check("req_addr", s_req_addr, mpc);
            check("ifid_valid", 32'(s_ifid_valid), 32'(mq.size() > 0));
            if (mq.size() > 0 && s_ifid_valid) begin
                check("ifid_pc", s_ifid_pc, mq[0].pc);
                check("ifid_instr", s_ifid_instr, mq[0].instr);
            end
            check("misalign", 32'(s_mis), 32'(mis_exp));
        end

        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            fire = s_req_valid && imem_req_ready;
            if (pop_now) void'(mq.pop_front());
            if (imem_rsp_valid) begin
                h = mem.pop_front();
                if (!redirect_valid && h.epoch == epoch)
                    mq.push_back('{pc: h.mdl_addr, instr: word_of(h.mdl_addr)});
            end
            if (redirect_valid) begin
                mq.delete();
                epoch++;
                mpc     = {redirect_pc[31:2], 2'b00};
                mis_exp = (redirect_pc[1:0] != 2'b00);
            end else begin
                mis_exp = 1'b0;
            end
            if (fire) begin
                l = lat_rand ? int'($urandom_range(1, 3)) : lat;
                mem.push_back('{dut_addr: s_req_addr, mdl_addr: mpc, epoch: epoch, due: cyc + l});
                mpc = mpc + 32'd4;
            end
            run = 1'b1;
        end
        cyc++;
    endtask

    task automatic wait_ifid(input int budget);
        for (int i = 0; i < budget; i++) begin
            cycle();
            if (s_ifid_valid) break;
        end
    endtask

    task automatic redirect_to(input logic [31:0] target);
        redir_next   = 1'b1;
        redir_target = target;
        cycle();
        redir_next   = 1'b0;
    endtask

    initial begin
        vectors = 0; miscompares = 0; cyc = 0; epoch = 0;
        mpc = 32'h0; run = 1'b0; mis_exp = 1'b0;
        rst_n = 1'b0; rst_req = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; dec_kill = 1'b0; ifid_ready = 1'b0;
        p_mready = 100; p_ready = 100; p_kill = 0; p_redir = 0;
        lat = 1; lat_rand = 1'b0; redir_next = 1'b0; redir_target = 32'h0;

        // Reset release, 1-cycle memory, decode always ready.
        repeat (3) cycle();
        rst_req = 1'b1;
        cycle(); check("boot_no_req", 32'(s_req_valid), 32'd0);
        cycle(); check("first_req", 32'(s_req_valid), 32'd1);
                 check("first_addr", s_req_addr, 32'h0);
        cycle(); check("no_ifid_yet", 32'(s_ifid_valid), 32'd0);
                 check("second_addr", s_req_addr, 32'h4);
        cycle(); check("first_valid", 32'(s_ifid_valid), 32'd1);
                 check("first_pc", s_ifid_pc, 32'h0);
                 check("first_instr", s_ifid_instr, 32'hC0DE_0003);
        cycle(); check("second_pc", s_ifid_pc, 32'h4);
                 check("second_instr", s_ifid_instr, 32'hC0DA_0003);
        cycle(); check("third_pc", s_ifid_pc, 32'h8);

        // Backpressure: queue fills, requests stop, then resume.
        p_ready = 0;
        repeat (5) cycle();
        check("bp_stall", 32'(s_req_valid), 32'd0);
        check("bp_held", 32'(s_ifid_valid), 32'd1);
        p_ready = 100;
        repeat (8) cycle();

        // Redirect with two requests in flight on a 3-cycle memory.
        lat = 3;
        repeat (8) cycle();
        redirect_to(32'h0000_0100);
        wait_ifid(20);
        check("redir_valid", 32'(s_ifid_valid), 32'd1);
        check("redir_pc", s_ifid_pc, 32'h0000_0100);
        check("redir_instr", s_ifid_instr, 32'hC1DE_0003);

        // Misaligned redirect target.
        lat = 1;
        repeat (6) cycle();
        redirect_to(32'h0000_0202);
        cycle(); check("mis_pulse", 32'(s_mis), 32'd1);
                 check("mis_addr", s_req_addr, 32'h0000_0200);
        cycle(); check("mis_clear", 32'(s_mis), 32'd0);

        // dec_kill with two queued words at 0x10 and 0x14.
        p_ready = 0;
        redirect_to(32'h0000_0010);
        repeat (6) cycle();
        check("kill_pre_pc", s_ifid_pc, 32'h0000_0010);
        check("kill_pre_stall", 32'(s_req_valid), 32'd0);
        p_kill = 100; p_mready = 0;
        cycle(); check("kill_head", s_ifid_pc, 32'h0000_0010);
        p_kill = 0;
        cycle(); check("kill_next_pc", s_ifid_pc, 32'h0000_0014);
                 check("kill_next_instr", s_ifid_instr, 32'hC0CA_0003);
                 check("kill_pc_kept", s_req_addr, 32'h0000_0018);
        p_ready = 100; p_mready = 100;
        repeat (8) cycle();

        // Random traffic.
        p_ready = 70; p_mready = 70; p_kill = 10; p_redir = 4; lat_rand = 1'b1;
        repeat (3000) cycle();

        // Reset asserted with a full queue.
        p_ready = 0; p_mready = 100; p_kill = 0; p_redir = 0; lat_rand = 1'b0; lat = 1;
        repeat (8) cycle();
        check("prerst_full", 32'(s_ifid_valid), 32'd1);
        rst_req = 1'b0;
        repeat (2) cycle();
        rst_req = 1'b1; p_ready = 100;
        wait_ifid(10);
        check("restart_valid", 32'(s_ifid_valid), 32'd1);
        check("restart_pc", s_ifid_pc, 32'h0);
        check("restart_instr", s_ifid_instr, 32'hC0DE_0003);
        repeat (4) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
